fetch_sequencer: RTL and testbench
==================================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: instruction/data width.
REQ-002 Parameter BOOT_CYCLES, default 4: idle cycles after reset release before the first fetch.
REQ-003 Parameter TIMEOUT, default 255: maximum WAIT/DROP cycles before a request is reissued (8-bit counter).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 stallF  input  1  hazard-unit stall; fetch must hold its current instruction.
REQ-007 PCSrcE  input  1  execute-stage redirect (taken branch/JAL/JALR); PC loads target when pc_enable=1.
REQ-008 imem_ack  input  1  single-cycle pulse; instruction memory returns data for the last request.
REQ-009 imem_rdata  input  DATA_WIDTH  returned instruction, valid only when imem_ack=1.
REQ-010 imem_req  output  1  single-cycle request pulse to instruction memory at the current PC.
REQ-011 pc_enable  output  1  combinational; drives the PC register enable.
REQ-012 instrF  output  DATA_WIDTH  registered captured instruction.
REQ-013 validF  output  1  registered; instrF holds the instruction for the current PC.
REQ-014 flushD  output  1  combinational; squashes the decode-stage register this cycle.
REQ-015 timeout_err  output  1  sticky; a timeout occurred since reset.

Function
REQ-016 FSM states: BOOT, REQ, WAIT, HOLD, DROP; exactly one state is active at a time.
REQ-017 BOOT: all outputs 0; after BOOT_CYCLES cycles, go to REQ.
REQ-018 REQ: imem_req=1 for exactly one cycle, clear wait counter, go to WAIT.
REQ-019 WAIT with imem_ack=1 and PCSrcE=0: instrF<=imem_rdata, validF<=1; if stallF=0, pc_enable=1 and go to REQ, otherwise go to HOLD.
REQ-020 WAIT with imem_ack=1 and PCSrcE=1: data discarded, validF<=0, flushD=1, pc_enable=1, go to REQ.
REQ-021 WAIT with PCSrcE=1 and imem_ack=0: flushD=1, pc_enable=1, validF<=0, go to DROP.
REQ-022 DROP: the next imem_ack is discarded with instrF unchanged, then go to REQ; a further PCSrcE in DROP asserts flushD and pc_enable again and remains in DROP.
REQ-023 HOLD: instrF and validF are held; when stallF=0, pc_enable=1 and go to REQ.
REQ-024 Redirect has priority over stall in every state except BOOT.
REQ-025 HOLD with PCSrcE=1: flushD=1, pc_enable=1, validF<=0, go to REQ.
REQ-026 validF clears on the clock edge on which pc_enable=1 (the PC advances); it is set only by a capture in WAIT.
REQ-027 Wait counter increments each cycle in WAIT/DROP and saturates at 8 bits.
REQ-028 Timeout: when the wait counter reaches TIMEOUT without imem_ack, set timeout_err and go to REQ with the PC unchanged (reissue).
REQ-029 imem_ack in BOOT, REQ or HOLD is ignored; no state or output changes.
REQ-030 pc_enable and imem_req are never high in the same cycle.
REQ-031 Fetch throughput: one instruction per (memory latency + 1) cycles with no stalls.

Reset
REQ-032 While reset=1, asynchronously: state=BOOT, boot/wait counters=0, instrF=0, validF=0, timeout_err=0; imem_req, pc_enable and flushD are 0.
REQ-033 Reset asserted mid-request abandons the outstanding fetch; a late imem_ack after release falls in BOOT and is ignored.

Structure
REQ-034 The state enum and the BOOT_CYCLES/TIMEOUT defaults live in the shared package fetch_pkg.
REQ-035 The design is a single module; the wait counter may be a sub-module sat_counter (8-bit, clear/increment, saturating).

Verification
REQ-036 Reset release, ack 2 cycles after each req, no stall -> first imem_req in cycle 5 after release; pc_enable pulses every 3 cycles; instrF sequence equals the memory words.
REQ-037 stallF=1 for 4 cycles after a capture of 0x00500093 -> HOLD; instrF and validF held; pc_enable=0 until stallF falls, then pc_enable=1 for 1 cycle.
REQ-038 PCSrcE pulse in WAIT, ack of 0xDEADBEEF next cycle -> flushD=1 and pc_enable=1 in the redirect cycle; 0xDEADBEEF never appears on instrF; next imem_req follows the dropped ack.
REQ-039 PCSrcE and imem_ack in the same cycle -> validF=0, flushD=1, pc_enable=1, state REQ next cycle.
REQ-040 No ack for 255 cycles -> timeout_err=1 (sticky); imem_req reissued with pc_enable=0; a later ack is captured normally.
REQ-041 Reset asserted in WAIT, then ack arriving 1 cycle after release -> ack ignored; outputs stay at reset values until BOOT completes.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and default parameters for the instruction fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DROP
  } fetch_state_t;

  localparam int BOOT_CYCLES_DEFAULT = 4;
  localparam int TIMEOUT_DEFAULT     = 255;
  localparam int WAIT_CNT_W          = 8;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues imem requests, captures returned
// instructions and arbitrates stall, redirect and timeout.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BOOT_CYCLES = BOOT_CYCLES_DEFAULT,
  parameter int TIMEOUT     = TIMEOUT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stallF,
  input  logic                  PCSrcE,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic                  imem_req,
  output logic                  pc_enable,
  output logic [DATA_WIDTH-1:0] instrF,
  output logic                  validF,
  output logic                  flushD,
  output logic                  timeout_err
);

  localparam int BOOT_W = (BOOT_CYCLES > 2) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BOOT_W-1:0]     BOOT_LAST    = BOOT_W'(BOOT_CYCLES - 1);
  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

  fetch_state_t r_state;
  fetch_state_t w_nextState;

  logic [BOOT_W-1:0]     r_bootCnt;
  logic [DATA_WIDTH-1:0] r_instrF;
  logic                  r_validF;
  logic                  r_timeoutErr;
  logic [WAIT_CNT_W-1:0] w_waitCnt;

  logic w_imemReq;
  logic w_pcEnable;
  logic w_flushD;
  logic w_capture;
  logic w_setTimeout;
  logic w_waitClear;
  logic w_waitInc;
  logic w_timeout;

  sat_counter #(
    .WIDTH(WAIT_CNT_W)
  ) u_waitCounter (
    .clk    (clk),
    .reset  (reset),
    .i_clear(w_waitClear),
    .i_inc  (w_waitInc),
    .o_count(w_waitCnt)
  );

  // Timeout fires on the cycle whose edge would bring the count to TIMEOUT.
  assign w_timeout = (w_waitCnt >= TIMEOUT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bootCnt <= '0;
    end else if ((r_state == ST_BOOT) && (r_bootCnt != BOOT_LAST)) begin
      r_bootCnt <= r_bootCnt + BOOT_W'(1);
    end
  end

  always_comb begin
    w_nextState  = r_state;
    w_imemReq    = 1'b0;
    w_pcEnable   = 1'b0;
    w_flushD     = 1'b0;
    w_capture    = 1'b0;
    w_setTimeout = 1'b0;
    w_waitClear  = 1'b0;
    w_waitInc    = 1'b0;
    unique case (r_state)
      ST_BOOT: begin
        if (r_bootCnt == BOOT_LAST) begin
          w_nextState = ST_REQ;
        end
      end
      ST_REQ: begin
        // A redirect here is taken first; the request goes out next cycle at the new PC.
        if (PCSrcE) begin
          w_flushD   = 1'b1;
          w_pcEnable = 1'b1;
        end else begin
          w_imemReq   = 1'b1;
          w_waitClear = 1'b1;
          w_nextState = ST_WAIT;
        end
      end
      ST_WAIT: begin
        w_waitInc = 1'b1;
        if (PCSrcE) begin
          w_flushD    = 1'b1;
          w_pcEnable  = 1'b1;
          w_nextState = imem_ack ? ST_REQ : ST_DROP;
        end else if (imem_ack) begin
          w_capture = 1'b1;
          if (!stallF) begin
            w_pcEnable  = 1'b1;
            w_nextState = ST_REQ;
          end else begin
            w_nextState = ST_HOLD;
          end
        end else if (w_timeout) begin
          w_setTimeout = 1'b1;
          w_nextState  = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (PCSrcE) begin
          w_flushD    = 1'b1;
          w_pcEnable  = 1'b1;
          w_nextState = ST_REQ;
        end else if (!stallF) begin
          w_pcEnable  = 1'b1;
          w_nextState = ST_REQ;
        end
      end
      ST_DROP: begin
        w_waitInc = 1'b1;
        if (PCSrcE) begin
          w_flushD   = 1'b1;
          w_pcEnable = 1'b1;
          if (imem_ack) begin
            w_nextState = ST_REQ;
          end
        end else if (imem_ack) begin
          w_nextState = ST_REQ;
        end else if (w_timeout) begin
          w_setTimeout = 1'b1;
          w_nextState  = ST_REQ;
        end
      end
      default: begin
        w_nextState = ST_BOOT;
      end
    endcase
  end

  // A capture wins over the clear when the PC advances on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instrF <= '0;
      r_validF <= 1'b0;
    end else if (w_capture) begin
      r_instrF <= imem_rdata;
      r_validF <= 1'b1;
    end else if (w_pcEnable) begin
      r_validF <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timeoutErr <= 1'b0;
    end else if (w_setTimeout) begin
      r_timeoutErr <= 1'b1;
    end
  end

  assign imem_req    = w_imemReq;
  assign pc_enable   = w_pcEnable;
  assign flushD      = w_flushD;
  assign instrF      = r_instrF;
  assign validF      = r_validF;
  assign timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer; captured instructions are checked
// against a scoreboard queue by an independent monitor.
module tb_fetch_sequencer;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          stallF;
  logic          PCSrcE;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;
  logic          imem_req;
  logic          pc_enable;
  logic [DW-1:0] instrF;
  logic          validF;
  logic          flushD;
  logic          timeout_err;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] sbQueue[$];

  always #5 clk = ~clk;

  fetch_sequencer #(
    .DATA_WIDTH (DW),
    .BOOT_CYCLES(4),
    .TIMEOUT    (255)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .stallF     (stallF),
    .PCSrcE     (PCSrcE),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .imem_req   (imem_req),
    .pc_enable  (pc_enable),
    .instrF     (instrF),
    .validF     (validF),
    .flushD     (flushD),
    .timeout_err(timeout_err)
  );

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // One cycle: drive just after the rising edge, return mid-cycle for sampling.
  task automatic applyStimulus(input logic st, input logic pc, input logic ack,
                               input logic [DW-1:0] rd);
    @(posedge clk);
    #1;
    stallF     = st;
    PCSrcE     = pc;
    imem_ack   = ack;
    imem_rdata = rd;
    @(negedge clk);
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, '1);
  endtask

  task automatic expectReq(input string name);
    idleCycle();
    checkOutput(name, imem_req, 1'b1);
    checkOutput({name, "_pcEn"}, pc_enable, 1'b0);
  endtask

  task automatic doFetch(input logic [DW-1:0] word, input string name);
    expectReq({name, "_req"});
    idleCycle();
    checkOutput({name, "_waitPcEn"}, pc_enable, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, word);
    sbQueue.push_back(word);
    checkOutput({name, "_ackPcEn"}, pc_enable, 1'b1);
    checkOutput({name, "_ackFlush"}, flushD, 1'b0);
  endtask

  // Monitor: pops the scoreboard on every capture and checks output invariants.
  initial begin
    logic [DW-1:0] prevInstr;
    logic          prevValid;
    logic [DW-1:0] expWord;
    prevInstr = '0;
    prevValid = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (imem_req || pc_enable) begin
          checkOutput("reqPcEnExclusive", {31'd0, imem_req && pc_enable}, '0);
        end
        if (validF && (!prevValid || (instrF != prevInstr))) begin
          if (sbQueue.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpectedCapture: got 0x%0h expected no capture", instrF);
          end else begin
            expWord = sbQueue.pop_front();
            checkOutput("capture", instrF, expWord);
          end
        end else if (!validF && (instrF != prevInstr)) begin
          checks++;
          failures++;
          $display("[TB] FAIL invalidCapture: got 0x%0h expected 0x%0h", instrF, prevInstr);
        end
      end
      prevInstr = instrF;
      prevValid = validF;
    end
  end

  initial begin
    int   n;
    logic seen;
    logic pcEnSeen;

    reset      = 1'b1;
    stallF     = 1'b0;
    PCSrcE     = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstReq", imem_req, 1'b0);
    checkOutput("rstPcEn", pc_enable, 1'b0);
    checkOutput("rstFlush", flushD, 1'b0);
    checkOutput("rstValid", validF, 1'b0);
    checkOutput("rstInstr", instrF, '0);
    checkOutput("rstTimeout", timeout_err, 1'b0);

    // Boot: release is cycle 1, first request lands in cycle 5.
    @(posedge clk);
    #1;
    reset      = 1'b0;
    PCSrcE     = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = '1;
    @(negedge clk);
    checkOutput("boot1Req", imem_req, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hAAAA_5555);
    checkOutput("boot2Req", imem_req, 1'b0);
    checkOutput("boot2PcEn", pc_enable, 1'b0);
    checkOutput("boot2Flush", flushD, 1'b0);
    checkOutput("boot2Valid", validF, 1'b0);
    idleCycle();
    checkOutput("boot3Req", imem_req, 1'b0);
    idleCycle();
    checkOutput("boot4Req", imem_req, 1'b0);

    doFetch(32'h0000_0013, "fetch1");
    doFetch(32'h0010_0113, "fetch2");
    doFetch(32'h0020_0193, "fetch3");

    // Stall for 4 cycles starting at the capture; an ack during HOLD is ignored.
    expectReq("stallReq");
    idleCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0050_0093);
    sbQueue.push_back(32'h0050_0093);
    checkOutput("stallAckPcEn", pc_enable, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, (i == 1), 32'h1111_1111);
      checkOutput("holdPcEn", pc_enable, 1'b0);
      checkOutput("holdReq", imem_req, 1'b0);
      checkOutput("holdValid", validF, 1'b1);
      checkOutput("holdInstr", instrF, 32'h0050_0093);
    end
    idleCycle();
    checkOutput("releasePcEn", pc_enable, 1'b1);
    expectReq("reqAfterHold");
    checkOutput("reqAfterHoldValid", validF, 1'b0);

    // Redirect in WAIT, a second redirect in DROP, then the stale ack is dropped.
    applyStimulus(1'b0, 1'b1, 1'b0, '1);
    checkOutput("redirFlush", flushD, 1'b1);
    checkOutput("redirPcEn", pc_enable, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, '1);
    checkOutput("dropRedirFlush", flushD, 1'b1);
    checkOutput("dropRedirPcEn", pc_enable, 1'b1);
    checkOutput("dropValid", validF, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    checkOutput("dropAckFlush", flushD, 1'b0);
    checkOutput("dropAckPcEn", pc_enable, 1'b0);
    checkOutput("dropAckReq", imem_req, 1'b0);
    expectReq("reqAfterDrop");
    checkOutput("reqAfterDropInstr", instrF, 32'h0050_0093);

    // Redirect and ack in the same cycle.
    idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0040_0213);
    sbQueue.push_back(32'h0040_0213);
    checkOutput("fetch4PcEn", pc_enable, 1'b1);
    expectReq("simReq");
    idleCycle();
    checkOutput("simWaitValid", validF, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hBADC_0DE5);
    checkOutput("simFlush", flushD, 1'b1);
    checkOutput("simPcEn", pc_enable, 1'b1);
    expectReq("reqAfterSim");
    checkOutput("reqAfterSimValid", validF, 1'b0);

    // Redirect beats stall while holding.
    idleCycle();
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0060_0293);
    sbQueue.push_back(32'h0060_0293);
    checkOutput("holdRedirAckPcEn", pc_enable, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, '1);
    checkOutput("holdRedirFlush", flushD, 1'b1);
    checkOutput("holdRedirPcEn", pc_enable, 1'b1);
    expectReq("reqAfterHoldRedir");
    checkOutput("reqAfterHoldRedirValid", validF, 1'b0);
    checkOutput("preTimeoutErr", timeout_err, 1'b0);

    // No ack: the request is reissued 256 cycles after the original one.
    n        = 0;
    seen     = 1'b0;
    pcEnSeen = 1'b0;
    while (!seen && (n < 300)) begin
      idleCycle();
      n++;
      if (pc_enable) pcEnSeen = 1'b1;
      if (imem_req) seen = 1'b1;
    end
    checkOutput("timeoutReissue", seen, 1'b1);
    checkOutput("timeoutGap", n, 256);
    checkOutput("timeoutNoPcEn", pcEnSeen, 1'b0);
    checkOutput("timeoutErr", timeout_err, 1'b1);
    idleCycle();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0070_0313);
    sbQueue.push_back(32'h0070_0313);
    checkOutput("postTimeoutPcEn", pc_enable, 1'b1);
    expectReq("postTimeoutReq");
    checkOutput("timeoutSticky", timeout_err, 1'b1);

    // Reset in WAIT; an ack one cycle after release must be ignored.
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midRstValid", validF, 1'b0);
    checkOutput("midRstInstr", instrF, '0);
    checkOutput("midRstTimeout", timeout_err, 1'b0);
    checkOutput("midRstReq", imem_req, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reboot1Req", imem_req, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'hCAFE_F00D);
    checkOutput("lateAckValid", validF, 1'b0);
    checkOutput("lateAckInstr", instrF, '0);
    checkOutput("lateAckPcEn", pc_enable, 1'b0);
    checkOutput("lateAckReq", imem_req, 1'b0);
    idleCycle();
    checkOutput("reboot3Req", imem_req, 1'b0);
    idleCycle();
    checkOutput("reboot4Instr", instrF, '0);
    checkOutput("reboot4Req", imem_req, 1'b0);
    doFetch(32'h0080_0393, "rebootFetch");

    idleCycle();
    idleCycle();
    checkOutput("sbEmpty", sbQueue.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
